// File: rtl/rx_cmd_sequencer.sv
// Frames the rx PIE bit stream into Gen2 commands and sequences the rx reset
// around replies, re-arm after each command and error recovery.
module rx_cmd_sequencer #(
  parameter int unsigned TX_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bitout,
  input  logic        bitclk,
  input  logic        rx_overflow_reset,
  input  logic        reply_req,
  input  logic        tx_done,
  output logic        rx_rst,
  output logic        cmd_valid,
  output logic [2:0]  cmd_id,
  output logic [39:0] frame,
  output logic [5:0]  frame_len,
  output logic        tx_go,
  output logic        frame_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, OPCODE, PAYLOAD, DONE, DECIDE, TX_WAIT, REARM, ABORT
  } state_t;

  localparam logic [11:0] TIMEOUT_LAST = 12'(TX_TIMEOUT - 1);

  state_t      state_reg, state_next;
  logic        bitclk_d_reg;
  logic [39:0] frame_reg, frame_next, shifted_frame;
  logic [5:0]  len_reg, len_next, shifted_len;
  logic [5:0]  exp_len_reg, exp_len_next, op_len;
  logic [2:0]  cmd_id_reg, cmd_id_next, op_id;
  logic [11:0] cnt_reg, cnt_next;
  logic        rx_rst_reg, cmd_valid_reg, tx_go_reg, frame_err_reg, busy_reg;
  logic        rx_rst_next, cmd_valid_next, tx_go_next, frame_err_next, busy_next;
  logic        bit_edge, capture, op_match, op_bad, timeout_hit;

  assign bit_edge = bitclk && !bitclk_d_reg;
  // Overflow beats a same-cycle bit once framing has started; IDLE ignores it.
  assign capture  = bit_edge && ((state_reg == IDLE) ||
                    ((state_reg == OPCODE || state_reg == PAYLOAD) && !rx_overflow_reset));
  assign shifted_frame = (state_reg == IDLE) ? {39'd0, bitout} : {frame_reg[38:0], bitout};
  assign shifted_len   = (state_reg == IDLE) ? 6'd1 : len_reg + 6'd1;
  assign timeout_hit   = (state_reg == TX_WAIT) && !tx_done && (cnt_reg == TIMEOUT_LAST);

  // Opcode decode on the frame as it will look after the bit now arriving.
  always_comb begin
    op_match = 1'b0;
    op_bad   = 1'b0;
    op_id    = 3'd0;
    op_len   = 6'd0;
    case (shifted_len)
      6'd2: begin
        if (shifted_frame[1:0] == 2'b00) begin
          op_match = 1'b1; op_id = 3'd0; op_len = 6'd4;
        end else if (shifted_frame[1:0] == 2'b01) begin
          op_match = 1'b1; op_id = 3'd1; op_len = 6'd18;
        end
      end
      6'd4: begin
        if (shifted_frame[3:0] == 4'b1000) begin
          op_match = 1'b1; op_id = 3'd2; op_len = 6'd22;
        end else if (shifted_frame[3:0] == 4'b1001) begin
          op_match = 1'b1; op_id = 3'd3; op_len = 6'd9;
        end else if (shifted_frame[3:1] == 3'b101) begin
          op_bad = 1'b1;
        end
      end
      6'd8: begin
        if (shifted_frame[7:0] == 8'hC0) begin
          op_match = 1'b1; op_id = 3'd4; op_len = 6'd8;
        end else if (shifted_frame[7:0] == 8'hC1) begin
          op_match = 1'b1; op_id = 3'd5; op_len = 6'd40;
        end else begin
          op_bad = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bit_edge) state_next = OPCODE;
      OPCODE: begin
        if (rx_overflow_reset) state_next = ABORT;
        else if (bit_edge) begin
          if (op_bad)        state_next = ABORT;
          else if (op_match) state_next = (shifted_len == op_len) ? DONE : PAYLOAD;
        end
      end
      PAYLOAD: begin
        if (rx_overflow_reset)                             state_next = ABORT;
        else if (bit_edge && shifted_len == exp_len_reg) state_next = DONE;
      end
      DONE:    state_next = DECIDE;
      DECIDE:  state_next = reply_req ? TX_WAIT : REARM;
      TX_WAIT: if (tx_done || timeout_hit) state_next = REARM;
      REARM:   state_next = IDLE;
      ABORT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    frame_next     = frame_reg;
    len_next       = len_reg;
    cmd_id_next    = cmd_id_reg;
    exp_len_next   = exp_len_reg;
    cnt_next       = (state_reg == TX_WAIT) ? cnt_reg + 12'd1 : 12'd0;
    if (capture) begin
      frame_next = shifted_frame;
      len_next   = shifted_len;
    end
    if (capture && state_reg == OPCODE && op_match) begin
      cmd_id_next  = op_id;
      exp_len_next = op_len;
    end
    cmd_valid_next = (state_reg == DONE);
    tx_go_next     = (state_reg == DECIDE) && reply_req;
    rx_rst_next    = (state_next == TX_WAIT) || (state_next == REARM) || (state_next == ABORT);
    frame_err_next = (state_next == ABORT) || timeout_hit;
    busy_next      = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitclk_d_reg  <= 1'b0;
      frame_reg     <= '0;
      len_reg       <= '0;
      cmd_id_reg    <= '0;
      exp_len_reg   <= '0;
      cnt_reg       <= '0;
      rx_rst_reg    <= 1'b0;
      cmd_valid_reg <= 1'b0;
      tx_go_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      bitclk_d_reg  <= bitclk;
      frame_reg     <= frame_next;
      len_reg       <= len_next;
      cmd_id_reg    <= cmd_id_next;
      exp_len_reg   <= exp_len_next;
      cnt_reg       <= cnt_next;
      rx_rst_reg    <= rx_rst_next;
      cmd_valid_reg <= cmd_valid_next;
      tx_go_reg     <= tx_go_next;
      frame_err_reg <= frame_err_next;
      busy_reg      <= busy_next;
    end
  end

  assign rx_rst    = rx_rst_reg;
  assign cmd_valid = cmd_valid_reg;
  assign cmd_id    = cmd_id_reg;
  assign frame     = frame_reg;
  assign frame_len = len_reg;
  assign tx_go     = tx_go_reg;
  assign frame_err = frame_err_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_rx_cmd_sequencer.sv
// Scoreboard bench for rx_cmd_sequencer: stimulus predicts output events from
// the command table, a negedge monitor pops and compares them as they appear.
module tb_rx_cmd_sequencer;
  localparam int TO = 4095;
  localparam int EV_CMD = 0, EV_GO = 1, EV_ERR = 2, EV_RISE = 3, EV_FALL = 4;
  localparam int OP_BITS [6] = '{2, 2, 4, 4, 8, 8};
  localparam int OP_CODE [6] = '{0, 1, 8, 9, 192, 193};
  localparam int CMD_LEN [6] = '{4, 18, 22, 9, 8, 40};

  logic clk = 0, reset = 1, bitout = 0, bitclk = 0;
  logic rx_overflow_reset = 0, reply_req = 0, tx_done = 0;
  logic rx_rst, cmd_valid, tx_go, frame_err, busy;
  logic [2:0] cmd_id;
  logic [39:0] frame;
  logic [5:0] frame_len;
  int cyc = 0, n_checks = 0, n_pass = 0;
  logic rx_rst_prev = 0;

  typedef struct {
    int kind;
    int at;
    int id;
    int len;
    logic [39:0] frm;
  } ev_t;
  ev_t exp_q[$];

  rx_cmd_sequencer #(.TX_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .bitout(bitout), .bitclk(bitclk),
    .rx_overflow_reset(rx_overflow_reset), .reply_req(reply_req), .tx_done(tx_done),
    .rx_rst(rx_rst), .cmd_valid(cmd_valid), .cmd_id(cmd_id), .frame(frame),
    .frame_len(frame_len), .tx_go(tx_go), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind; e.at = at; e.id = 0; e.len = 0; e.frm = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_cmd(input int at, input int id, input int len, input logic [39:0] frm);
    ev_t e;
    e.kind = EV_CMD; e.at = at; e.id = id; e.len = len; e.frm = frm;
    exp_q.push_back(e);
  endtask

  task automatic see(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, expected no event", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", 64'(kind), 64'(e.kind));
      check("event_cycle", 64'(cyc), 64'(e.at));
      if (kind == EV_CMD && e.kind == EV_CMD) begin
        check("cmd_id", 64'(cmd_id), 64'(e.id));
        check("frame_len", 64'(frame_len), 64'(e.len));
        check("frame", 64'(frame), 64'(e.frm));
        $display("cmd id=%0d len=%0d frame=%010h at cycle %0d", cmd_id, frame_len, frame, cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (cmd_valid)                 see(EV_CMD);
      if (tx_go)                     see(EV_GO);
      if (frame_err)                 see(EV_ERR);
      if (rx_rst && !rx_rst_prev)    see(EV_RISE);
      if (!rx_rst && rx_rst_prev)    see(EV_FALL);
    end
    rx_rst_prev <= rx_rst;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) tick();
  endtask

  function automatic logic [39:0] rand40();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[39:0];
  endfunction

  function automatic logic [39:0] with_op(input logic [39:0] r, input int code, input int k);
    logic [39:0] mask;
    mask = ((40'd1 << k) - 40'd1) << (40 - k);
    return (r & ~mask) | (40'(code) << (40 - k));
  endfunction

  // Reference: opcode prefixes are examined at 2, 4 and 8 bits only.
  // outcome 0 = command (len = full length), 1 = abort (len = bits taken).
  function automatic void classify(input logic [39:0] seq, input int n,
                                   output int outcome, output int id, output int len);
    int k;
    logic [7:0] p;
    bit decided;
    outcome = 2; id = 0; len = n; decided = 0; k = 2;
    while (!decided && k <= 8 && k <= n) begin
      p = seq[39:32] >> (8 - k);
      for (int e = 0; e < 6; e++)
        if (!decided && OP_BITS[e] == k && int'(p) == OP_CODE[e]) begin
          outcome = 0; id = e; len = CMD_LEN[e]; decided = 1;
        end
      if (!decided && ((k == 4 && p[3:1] == 3'b101) || k == 8)) begin
        outcome = 1; len = k; decided = 1;
      end
      k = k * 2;
    end
  endfunction

  // d: cycles from entering TX_WAIT to tx_done (>=2), or -1 for timeout.
  task automatic run_txn(input logic [39:0] seq, input int n, input bit reply,
                         input int d, input int ovf_idx, input bit noise);
    int outcome, id, len, nsend, c, fin;
    logic [39:0] efrm;
    classify(seq, n, outcome, id, len);
    if (ovf_idx >= 1 && ovf_idx < len) begin
      outcome = 1; nsend = ovf_idx + 1;
    end else nsend = len;
    efrm = seq >> (40 - len);
    reply_req = reply;
    c = 0; fin = 0;
    if (noise) begin
      tx_done = 1; rx_overflow_reset = 1;
      tick();
      tx_done = 0; rx_overflow_reset = 0;
    end
    for (int i = 0; i < nsend; i++) begin
      repeat ($urandom_range(1, 3)) tick();
      bitout = seq[39 - i];
      bitclk = 1;
      rx_overflow_reset = (i == ovf_idx);
      if (i == nsend - 1) begin
        c = cyc + 1;
        if (outcome == 1) begin
          push(EV_ERR, c); push(EV_RISE, c); push(EV_FALL, c + 1);
          fin = c + 1;
        end else begin
          push_cmd(c + 1, id, len, efrm);
          if (!reply) begin
            push(EV_RISE, c + 2); push(EV_FALL, c + 3);
            fin = c + 3;
          end else begin
            push(EV_GO, c + 2); push(EV_RISE, c + 2);
            if (d < 0) begin
              push(EV_ERR, c + 2 + TO); push(EV_FALL, c + 3 + TO);
              fin = c + 3 + TO;
            end else fin = c + 3 + d;
          end
        end
      end
      tick();
      bitclk = 0; rx_overflow_reset = 0;
    end
    if (outcome == 0 && reply) begin
      wait_cyc(c + 2);
      rx_overflow_reset = 1; bitclk = 1; bitout = 1;
      tick();
      rx_overflow_reset = 0; bitclk = 0;
      if (d >= 0) begin
        wait_cyc(c + 1 + d);
        tx_done = 1;
        push(EV_FALL, c + 3 + d);
        tick();
        tx_done = 0;
      end
    end
    wait_cyc(fin);
    @(negedge clk);
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_rx_rst", 64'(rx_rst), 64'd0);
    if (outcome == 0) begin
      check("held_frame", 64'(frame), 64'(efrm));
      check("held_len", 64'(frame_len), 64'(len));
      check("held_id", 64'(cmd_id), 64'(id));
    end
    $display("txn done: outcome=%0d id=%0d len=%0d reply=%0d at cycle %0d", outcome, id, len, reply, cyc);
    tick();
  endtask

  initial begin
    logic [39:0] s;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({rx_rst, cmd_valid, tx_go, frame_err, busy, cmd_id, frame, frame_len}), 64'd0);
    tick();
    reset = 0;
    repeat (2) tick();

    run_txn(with_op(rand40(), 4'b0010, 4), 4, 1'b1, 5, -1, 1'b0);
    run_txn(with_op(rand40(), 4'b1000, 4), 22, 1'b0, 2, -1, 1'b0);
    run_txn(with_op(rand40(), 8'hC1, 8), 40, 1'b1, 10, -1, 1'b0);
    run_txn(with_op(rand40(), 8'hC0, 8), 8, 1'b0, 2, -1, 1'b0);
    run_txn(with_op(rand40(), 4'b1010, 4), 4, 1'b0, 2, -1, 1'b0);
    run_txn(with_op(rand40(), 8'hFF, 8), 8, 1'b0, 2, -1, 1'b0);
    run_txn(with_op(rand40(), 2'b01, 2), 18, 1'b0, 2, 9, 1'b1);
    run_txn(with_op(rand40(), 4'b1001, 4), 9, 1'b1, -1, -1, 1'b1);

    // Asynchronous reset in the middle of an ACK payload.
    s = with_op(rand40(), 2'b01, 2);
    reply_req = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      bitout = s[39 - i]; bitclk = 1;
      tick();
      bitclk = 0;
    end
    check("mid_busy", 64'(busy), 64'd1);
    check("mid_len", 64'(frame_len), 64'd12);
    #1 reset = 1;
    #1 check("async_reset_clear", 64'({rx_rst, cmd_valid, tx_go, frame_err, busy, cmd_id, frame, frame_len}), 64'd0);
    tick();
    reset = 0;
    repeat (2) tick();

    for (int t = 0; t < 40; t++) begin
      int ch, n, code, k, ovf;
      ch = $urandom_range(0, 7);
      if (ch < 6) begin
        code = OP_CODE[ch]; k = OP_BITS[ch]; n = CMD_LEN[ch];
      end else if (ch == 6) begin
        code = $urandom_range(10, 11); k = 4; n = 4;
      end else begin
        code = 192 + $urandom_range(2, 63); k = 8; n = 8;
      end
      s = with_op(rand40(), code, k);
      ovf = ($urandom_range(0, 4) == 0) ? $urandom_range(1, n - 1) : -1;
      run_txn(s, n, 1'($urandom_range(0, 1)), $urandom_range(2, 30), ovf, 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
